// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard control unit.
// The datapath side (master) drives stage state and observes the
// stall/bubble/redirect controls; the controller side (slave) does the opposite.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [3:0]       D_icode;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic [3:0]       E_icode;
    logic [3:0]       E_dstM;
    logic             e_cnd;
    logic [3:0]       M_icode;
    logic             M_cnd;
    logic [63:0]      M_valA;
    logic [1:0]       m_stat;
    logic [3:0]       W_icode;
    logic [63:0]      W_valM;
    logic [1:0]       W_stat;

    logic             F_stall;
    logic             D_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             W_stall;
    logic             redirect_valid;
    logic [63:0]      redirect_pc;
    logic             halted;
    logic [CNT_W-1:0] mispredict_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] ret_cnt;

    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd,
               M_icode, M_cnd, M_valA, m_stat, W_icode, W_valM, W_stat,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
               redirect_valid, redirect_pc, halted,
               mispredict_cnt, stall_cnt, ret_cnt
    );

    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd,
               M_icode, M_cnd, M_valA, m_stat, W_icode, W_valM, W_stat,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
               redirect_valid, redirect_pc, halted,
               mispredict_cnt, stall_cnt, ret_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: detects load-use, jXX mispredict, ret drain and
// exceptional status, drives stage stall/bubble controls, redirects fetch,
// and keeps saturating performance counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W     = 32,
    parameter int RET_DRAIN = 3
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int DRAIN_W = (RET_DRAIN > 2) ? $clog2(RET_DRAIN) : 1;

    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_POP   = 4'hB;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] R_NONE  = 4'hF;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        RET_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t             state_q;
    logic [DRAIN_W-1:0] drainLeft_q;
    logic [CNT_W-1:0]   mispredCnt_q;
    logic [CNT_W-1:0]   stallCnt_q;
    logic [CNT_W-1:0]   retCnt_q;

    logic loadUse;
    logic mispred;
    logic retInPipe;
    logic excM;
    logic excW;
    logic retEntry;
    logic fStall;

    // Hazard detection from the current stage contents and controller state
    always_comb begin
        loadUse   = ((bus.E_icode == I_MRMOV) || (bus.E_icode == I_POP)) &&
                    (bus.E_dstM != R_NONE) &&
                    ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
        mispred   = (bus.E_icode == I_JXX) && !bus.e_cnd;
        retInPipe = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) ||
                    (bus.M_icode == I_RET) || (state_q == RET_WAIT);
        excM      = (bus.m_stat != 2'b00);
        excW      = (bus.W_stat != 2'b00);
        // A ret behind a load-use stall waits; a ret behind a mispredicted
        // jump is on the wrong path and gets squashed instead of drained.
        retEntry  = (state_q == RUN) && (bus.D_icode == I_RET) && !loadUse && !mispred;
    end

    // Combinational stage controls and fetch redirect, all forced low in reset
    always_comb begin
        fStall             = 1'b0;
        bus.D_stall        = 1'b0;
        bus.D_bubble       = 1'b0;
        bus.E_bubble       = 1'b0;
        bus.M_bubble       = 1'b0;
        bus.W_stall        = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        bus.halted         = 1'b0;
        if (!rst) begin
            if (state_q == HALT) begin
                fStall       = 1'b1;
                bus.D_bubble = 1'b1;
                bus.E_bubble = 1'b1;
                bus.M_bubble = 1'b1;
                bus.W_stall  = 1'b1;
                bus.halted   = 1'b1;
            end else begin
                fStall       = loadUse || retInPipe;
                bus.D_stall  = loadUse;
                bus.D_bubble = mispred || (retInPipe && !loadUse);
                bus.E_bubble = mispred || loadUse;
                bus.M_bubble = excM || excW;
                bus.W_stall  = excW;
                // A mispredicted jump is older than any ret in W's shadow, so it wins
                if ((bus.M_icode == I_JXX) && !bus.M_cnd) begin
                    bus.redirect_valid = 1'b1;
                    bus.redirect_pc    = bus.M_valA;
                end else if (bus.W_icode == I_RET) begin
                    bus.redirect_valid = 1'b1;
                    bus.redirect_pc    = bus.W_valM;
                end
            end
        end
        bus.F_stall = fStall;
    end

    // Ret-drain / halt state machine; a bad status in W overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            drainLeft_q <= '0;
        end else if (excW) begin
            state_q <= HALT;
        end else begin
            case (state_q)
                RUN: begin
                    if (retEntry) begin
                        state_q     <= RET_WAIT;
                        drainLeft_q <= DRAIN_W'(RET_DRAIN - 1);
                    end
                end
                RET_WAIT: begin
                    if (drainLeft_q != '0) begin
                        drainLeft_q <= drainLeft_q - 1'b1;
                    end else if (bus.W_icode == I_RET) begin
                        state_q <= RUN;
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q     <= RUN;
                    drainLeft_q <= '0;
                end
            endcase
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredCnt_q <= '0;
            stallCnt_q   <= '0;
            retCnt_q     <= '0;
        end else begin
            if (mispred && (state_q != HALT) && (mispredCnt_q != '1)) begin
                mispredCnt_q <= mispredCnt_q + 1'b1;
            end
            if (fStall && (stallCnt_q != '1)) begin
                stallCnt_q <= stallCnt_q + 1'b1;
            end
            if (retEntry && !excW && (retCnt_q != '1)) begin
                retCnt_q <= retCnt_q + 1'b1;
            end
        end
    end

    assign bus.mispredict_cnt = mispredCnt_q;
    assign bus.stall_cnt      = stallCnt_q;
    assign bus.ret_cnt        = retCnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;
    localparam logic [3:0] NOP = 4'h1;
    localparam logic [3:0] NR  = 4'hF;

    logic clk;
    logic rst;
    int   passCnt;
    int   totalCnt;

    pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();

    pipe_hazard_ctrl #(.CNT_W(32), .RET_DRAIN(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, posedges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Control bits packed as {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, redirect_valid}
    function automatic logic [6:0] ctrlVec();
        return {bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble,
                bus.M_bubble, bus.W_stall, bus.redirect_valid};
    endfunction

    // Drive one cycle of inputs on the falling edge, then let outputs settle
    task automatic applyStimulus(
        input logic r,
        input logic [3:0] dI, input logic [3:0] dA, input logic [3:0] dB,
        input logic [3:0] eI, input logic [3:0] eD, input logic eC,
        input logic [3:0] mI, input logic mC, input logic [63:0] mVA, input logic [1:0] mS,
        input logic [3:0] wI, input logic [63:0] wVM, input logic [1:0] wS);
        @(negedge clk);
        rst         = r;
        bus.D_icode = dI;
        bus.d_srcA  = dA;
        bus.d_srcB  = dB;
        bus.E_icode = eI;
        bus.E_dstM  = eD;
        bus.e_cnd   = eC;
        bus.M_icode = mI;
        bus.M_cnd   = mC;
        bus.M_valA  = mVA;
        bus.m_stat  = mS;
        bus.W_icode = wI;
        bus.W_valM  = wVM;
        bus.W_stat  = wS;
        #1;
    endtask

    task automatic idleStep();
        applyStimulus(1'b0, NOP, NR, NR, NOP, NR, 1'b1, NOP, 1'b1, 64'h0, 2'b00, NOP, 64'h0, 2'b00);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalCnt++;
        assert (observed === expected) passCnt++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    initial begin
        passCnt  = 0;
        totalCnt = 0;
        rst      = 1'b1;

        // Reset with random inputs: controls forced low, counters cleared
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                          4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
                          {$urandom, $urandom}, 2'($urandom), 4'($urandom),
                          {$urandom, $urandom}, 2'($urandom));
            checkOutput("rst_ctrl", 64'(ctrlVec()), 64'h0);
            checkOutput("rst_halted", 64'(bus.halted), 64'h0);
            checkOutput("rst_pc", bus.redirect_pc, 64'h0);
            checkOutput("rst_cnts", 64'(bus.stall_cnt | bus.mispredict_cnt | bus.ret_cnt), 64'h0);
        end
        idleStep();
        idleStep();
        checkOutput("idle_ctrl", 64'(ctrlVec()), 64'h0);
        checkOutput("idle_stall_cnt", 64'(bus.stall_cnt), 64'd0);

        // Load-use via mrmov on srcA, then via popq on srcB
        applyStimulus(1'b0, 4'h6, 4'h3, NR, 4'h5, 4'h3, 1'b1, NOP, 1'b1, 64'h0, 2'b00, NOP, 64'h0, 2'b00);
        checkOutput("lu_mrmov_ctrl", 64'(ctrlVec()), 64'b1101000);
        applyStimulus(1'b0, 4'h6, NR, 4'h4, 4'hB, 4'h4, 1'b1, NOP, 1'b1, 64'h0, 2'b00, NOP, 64'h0, 2'b00);
        checkOutput("lu_pop_ctrl", 64'(ctrlVec()), 64'b1101000);
        // No destination must never match an unused source
        applyStimulus(1'b0, 4'h6, NR, NR, 4'h5, NR, 1'b1, NOP, 1'b1, 64'h0, 2'b00, NOP, 64'h0, 2'b00);
        checkOutput("lu_none_ctrl", 64'(ctrlVec()), 64'h0);
        checkOutput("lu_stall_cnt", 64'(bus.stall_cnt), 64'd2);

        // Mispredict in E, then its redirect from M
        applyStimulus(1'b0, NOP, NR, NR, 4'h7, NR, 1'b0, NOP, 1'b1, 64'h0, 2'b00, NOP, 64'h0, 2'b00);
        checkOutput("mp_ctrl", 64'(ctrlVec()), 64'b0011000);
        applyStimulus(1'b0, NOP, NR, NR, NOP, NR, 1'b1, 4'h7, 1'b0, 64'h40, 2'b00, NOP, 64'h0, 2'b00);
        checkOutput("mp_redir_ctrl", 64'(ctrlVec()), 64'b0000001);
        checkOutput("mp_redir_pc", bus.redirect_pc, 64'h40);
        checkOutput("mp_cnt", 64'(bus.mispredict_cnt), 64'd1);
        // Mispredict together with a memory-stage exception: both bubbles
        applyStimulus(1'b0, NOP, NR, NR, 4'h7, NR, 1'b0, NOP, 1'b1, 64'h0, 2'b10, NOP, 64'h0, 2'b00);
        checkOutput("mp_excm_ctrl", 64'(ctrlVec()), 64'b0011100);
        // jXX redirect outranks a ret in W
        applyStimulus(1'b0, NOP, NR, NR, NOP, NR, 1'b1, 4'h7, 1'b0, 64'h40, 2'b00, 4'h9, 64'h100, 2'b00);
        checkOutput("prio_pc", bus.redirect_pc, 64'h40);
        checkOutput("prio_cnt", 64'(bus.mispredict_cnt), 64'd2);

        // Ret drain with W arriving on time: four stalled cycles
        applyStimulus(1'b0, 4'h9, NR, NR, NOP, NR, 1'b1, NOP, 1'b1, 64'h0, 2'b00, NOP, 64'h0, 2'b00);
        checkOutput("ret_d_ctrl", 64'(ctrlVec()), 64'b1010000);
        idleStep();
        checkOutput("ret_w1_ctrl", 64'(ctrlVec()), 64'b1010000);
        idleStep();
        checkOutput("ret_w2_ctrl", 64'(ctrlVec()), 64'b1010000);
        applyStimulus(1'b0, NOP, NR, NR, NOP, NR, 1'b1, NOP, 1'b1, 64'h0, 2'b00, 4'h9, 64'h100, 2'b00);
        checkOutput("ret_wb_ctrl", 64'(ctrlVec()), 64'b1010001);
        checkOutput("ret_wb_pc", bus.redirect_pc, 64'h100);
        idleStep();
        checkOutput("ret_done_ctrl", 64'(ctrlVec()), 64'h0);
        checkOutput("ret_cnt", 64'(bus.ret_cnt), 64'd1);
        checkOutput("ret_stall_cnt", 64'(bus.stall_cnt), 64'd6);

        // Ret drain with W late: stays stalled at drain zero until the ret reaches W
        applyStimulus(1'b0, 4'h9, NR, NR, NOP, NR, 1'b1, NOP, 1'b1, 64'h0, 2'b00, NOP, 64'h0, 2'b00);
        idleStep();
        idleStep();
        idleStep();
        idleStep();
        checkOutput("ret_hold_ctrl", 64'(ctrlVec()), 64'b1010000);
        applyStimulus(1'b0, NOP, NR, NR, NOP, NR, 1'b1, NOP, 1'b1, 64'h0, 2'b00, 4'h9, 64'h200, 2'b00);
        checkOutput("ret_late_pc", bus.redirect_pc, 64'h200);
        idleStep();
        checkOutput("ret_late_done", 64'(ctrlVec()), 64'h0);
        checkOutput("ret_late_cnt", 64'(bus.ret_cnt), 64'd2);

        // Load-use with ret in D: stall wins and the drain does not start
        applyStimulus(1'b0, 4'h9, 4'h3, NR, 4'h5, 4'h3, 1'b1, NOP, 1'b1, 64'h0, 2'b00, NOP, 64'h0, 2'b00);
        checkOutput("lu_ret_ctrl", 64'(ctrlVec()), 64'b1101000);
        idleStep();
        checkOutput("lu_ret_after", 64'(ctrlVec()), 64'h0);
        checkOutput("lu_ret_cnt", 64'(bus.ret_cnt), 64'd2);

        // Wrong-path ret behind a mispredicted jump is squashed
        applyStimulus(1'b0, 4'h9, NR, NR, 4'h7, NR, 1'b0, NOP, 1'b1, 64'h0, 2'b00, NOP, 64'h0, 2'b00);
        checkOutput("wp_ctrl", 64'(ctrlVec()), 64'b1011000);
        idleStep();
        checkOutput("wp_after", 64'(ctrlVec()), 64'h0);
        checkOutput("wp_ret_cnt", 64'(bus.ret_cnt), 64'd2);
        checkOutput("wp_mp_cnt", 64'(bus.mispredict_cnt), 64'd3);

        // Halt on W status, frozen while mispredict and redirect inputs are present
        applyStimulus(1'b0, NOP, NR, NR, NOP, NR, 1'b1, NOP, 1'b1, 64'h0, 2'b00, NOP, 64'h0, 2'b01);
        checkOutput("halt_entry_ctrl", 64'(ctrlVec()), 64'b0000110);
        checkOutput("halt_entry_flag", 64'(bus.halted), 64'h0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, NOP, NR, NR, 4'h7, NR, 1'b0, 4'h7, 1'b0, 64'h80, 2'b00, NOP, 64'h0, 2'b00);
            checkOutput("halt_ctrl", 64'(ctrlVec()), 64'b1011110);
            checkOutput("halt_flag", 64'(bus.halted), 64'h1);
        end

        // Reset out of HALT
        applyStimulus(1'b1, NOP, NR, NR, NOP, NR, 1'b1, NOP, 1'b1, 64'h0, 2'b00, NOP, 64'h0, 2'b00);
        checkOutput("halt_stall_cnt", 64'(bus.stall_cnt), 64'd24);
        checkOutput("halt_mp_cnt", 64'(bus.mispredict_cnt), 64'd3);
        checkOutput("halt_rst_ctrl", 64'(ctrlVec()), 64'h0);
        checkOutput("halt_rst_flag", 64'(bus.halted), 64'h0);
        idleStep();
        checkOutput("post_rst_ctrl", 64'(ctrlVec()), 64'h0);
        checkOutput("post_rst_flag", 64'(bus.halted), 64'h0);
        checkOutput("post_rst_cnts", 64'(bus.stall_cnt | bus.mispredict_cnt | bus.ret_cnt), 64'h0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
